mfcc_mel_filter_mac: RTL and testbench
======================================

// Module: mfcc_mel_filter_mac
// PURPOSE
//  Per-filter mel energy lane. Takes the power-spectrum bin stream from the FFT magnitude stage.
//  Drives the bin index into one mel weight ROM (9-bit addr, 8-bit unsigned weight, unregistered read).
//  Computes E = sum(P[k]*W[k]) over one frame and emits one energy word per frame to the log/DCT stage.
//  One instance per mel filter, each paired with its own weight ROM.
// PARAMETERS
//  PWR_W   32    width of unsigned power input
//  W_W     8     ROM weight width (matches ROM data width)
//  ROM_AW  9     ROM address width
//  NBINS   512   bins per frame, <= 2**ROM_AW
//  ACC_W   49    accumulator/output width; PWR_W+W_W+ROM_AW gives no overflow
// PORTS
//  clk       in   1       system clock
//  rst       in   1       asynchronous reset, active-high
//  s_valid   in   1       power bin valid
//  s_ready   out  1       lane accepts a bin
//  s_data    in   PWR_W   power bin P[k], unsigned
//  s_last    in   1       marks final bin of frame
//  rom_addr  out  ROM_AW  bin index to weight ROM; equals bin_cnt
//  rom_data  in   W_W     weight W[k]; combinational, valid in the same cycle as rom_addr
//  m_valid   out  1       frame energy valid
//  m_ready   in   1       downstream accepts energy
//  m_data    out  ACC_W   frame energy, unsigned
//  m_sat     out  1       accumulator saturated this frame (MFCC_MEL_ACC_SAT_EN only)
//  err_len   out  1       1-cycle pulse: frame length != NBINS
// BEHAVIOUR
//  Reset values: s_ready=0, m_valid=0, m_data=0, m_sat=0, err_len=0, rom_addr=0.
//    Internal state: bin_cnt=0, acc=0, state=ACCUM.
//  Reset mid-frame: partial frame is discarded. Lane returns to ACCUM with bin_cnt=0.
//  FSM ACCUM -> FLUSH -> OUTPUT -> ACCUM.
//  ACCUM: s_ready=1.
//    A beat is a cycle with s_valid&s_ready.
//    On a beat, prod_r <= s_data*rom_data (PWR_W+W_W bits, unsigned, no truncation) and prod_v <= 1.
//    Also on a beat, bin_cnt increments.
//    acc += prod_r one cycle after prod_v, so beat-to-acc latency is 2 cycles.
//  End of frame: the frame ends on a beat that has s_last=1 or bin_cnt==NBINS-1, whichever comes first.
//    err_len pulses 1 cycle after that beat if the two conditions disagree.
//    Then go to FLUSH.
//  FLUSH: s_ready=0. One cycle; the last product is added into acc.
//  OUTPUT: m_valid=1 and m_data=acc, held stable until m_ready. s_ready=0.
//    On m_valid&m_ready: acc=0, bin_cnt=0, m_sat cleared, state ACCUM. s_ready=1 on the next cycle.
//  Frame latency: m_valid rises 2 cycles after the final beat.
//  bin_cnt never wraps. It resets to 0 only at the output handshake or at rst.
//  s_valid low in ACCUM: bin_cnt, rom_addr and acc hold. prod_v=0, nothing is added.
//  Zero weight (rom_data=0) still counts as a bin; it adds 0.
// CONFIGURATION
//  MFCC_MEL_ACC_SAT_EN defined:
//    If acc+prod_r exceeds 2**ACC_W-1, acc clamps to all-ones and m_sat=1 for that frame.
//  MFCC_MEL_ACC_SAT_EN undefined:
//    acc wraps modulo 2**ACC_W; m_sat tied 0.
// STRUCTURE
//  Package mfcc_pkg holds:
//    NBINS, ROM_AW, W_W defaults;
//    state encoding localparams ST_ACCUM=2'd0, ST_FLUSH=2'd1, ST_OUTPUT=2'd2.
//  Sub-module mfcc_mel_mul_stage: registered unsigned multiply. Inputs P, W, en; outputs prod_r, prod_v.
//  The top holds the FSM, bin_cnt, acc, output register and error logic.
// TESTING
//  1 NBINS=512, P[k]=1000, ROM weight=k[7:0], s_valid always high
//    -> m_data=1000*sum(k mod 256)=65280000. m_valid 2 cycles after last beat. err_len never set.
//  2 Same frame with m_ready low for 10 cycles
//    -> m_data stable and s_ready=0 throughout; next frame starts the cycle after the handshake.
//  3 Random s_valid gaps (50%), P=7, weight=1
//    -> m_data=3584. rom_addr only changes on beats.
//  4 s_last on bin 99
//    -> frame closes, err_len pulse, m_data=sum over bins 0..99.
//    No s_last by bin 511 -> frame closes at 511, err_len pulse.
//  5 rst asserted at bin 300, released, full frame P=2 weight=3
//    -> m_data=3072. No residue from the aborted frame.
//  6 ACC_W=40, P=2**32-1, weight=255 (SAT_EN defined)
//    -> m_data=2**40-1, m_sat=1.
//    Undefined: m_data=(512*255*(2**32-1)) mod 2**40, m_sat=0.

Source files
------------

// File: rtl/mfcc_pkg.sv
// Shared defaults and FSM state encoding for the mel filter energy lane.
package mfcc_pkg;

  localparam int DEF_NBINS  = 512;
  localparam int DEF_ROM_AW = 9;
  localparam int DEF_W_W    = 8;

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  typedef enum logic [1:0] {
    S_ACCUM  = ST_ACCUM,
    S_FLUSH  = ST_FLUSH,
    S_OUTPUT = ST_OUTPUT
  } state_e;

endpackage

// File: rtl/mfcc_mel_mul_stage.sv
// Registered unsigned power x weight product with a matching valid flag.
module mfcc_mel_mul_stage #(
  parameter int PWR_W = 32,
  parameter int W_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PWR_W-1:0]       p_i,
  input  logic [W_W-1:0]         w_i,
  input  logic                   en_i,
  output logic [PWR_W+W_W-1:0]   prod_r_o,
  output logic                   prod_v_o
);

  localparam int PROD_W = PWR_W + W_W;

  // Capture the full-width product on every accepted bin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r_o <= '0;
      prod_v_o <= 1'b0;
    end else begin
      prod_v_o <= en_i;
      if (en_i) prod_r_o <= PROD_W'(p_i) * PROD_W'(w_i);
    end
  end

endmodule

// File: rtl/mfcc_mel_filter_mac.sv
// Per-filter mel energy lane: E = sum(P[k]*W[k]) over one frame.
// Optional feature macro: MFCC_MEL_ACC_SAT_EN (accumulator clamps instead of wrapping).
module mfcc_mel_filter_mac
  import mfcc_pkg::*;
#(
  parameter int PWR_W  = 32,
  parameter int W_W    = DEF_W_W,
  parameter int ROM_AW = DEF_ROM_AW,
  parameter int NBINS  = DEF_NBINS,
  parameter int ACC_W  = 49
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PWR_W-1:0]  s_data,
  input  logic              s_last,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [W_W-1:0]    rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_data,
  output logic              m_sat,
  output logic              err_len
);

  localparam int PROD_W = PWR_W + W_W;
  // One spare bit so the counter can step past the last bin without wrapping.
  localparam int CNT_W  = ROM_AW + 1;

  state_e            state_q;
  logic [CNT_W-1:0]  bin_cnt_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  m_data_q;
  logic              s_ready_q, m_valid_q, err_len_q;
  logic [PROD_W-1:0] prod_r;
  logic              prod_v;
  logic              beat, at_max, frame_end, out_hs;

  assign beat      = s_valid & s_ready_q & (state_q == S_ACCUM);
  assign at_max    = (bin_cnt_q == CNT_W'(NBINS - 1));
  assign frame_end = s_last | at_max;
  assign out_hs    = (state_q == S_OUTPUT) & m_ready;

  mfcc_mel_mul_stage #(.PWR_W(PWR_W), .W_W(W_W)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .p_i      (s_data),
    .w_i      (rom_data),
    .en_i     (beat),
    .prod_r_o (prod_r),
    .prod_v_o (prod_v)
  );

`ifdef MFCC_MEL_ACC_SAT_EN
  localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  logic [SUM_W-1:0] sum;
  logic             sat_q, sat_d;

  // Saturating accumulate; the sticky flag is cleared with the accumulator at handoff.
  always_comb begin
    sum   = SUM_W'(acc_q) + SUM_W'(prod_r);
    acc_d = acc_q;
    sat_d = sat_q;
    if (prod_v) begin
      if (|sum[SUM_W-1:ACC_W]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
    if (out_hs) begin
      acc_d = '0;
      sat_d = 1'b0;
    end
  end

  // Sticky saturation flag for the current frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end

  assign m_sat = sat_q;
`else
  // Wrapping accumulate, cleared at handoff.
  always_comb begin
    acc_d = acc_q;
    if (prod_v) acc_d = acc_q + ACC_W'(prod_r);
    if (out_hs) acc_d = '0;
  end

  assign m_sat = 1'b0;
`endif

  // Frame FSM with bin counter, accumulator and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_ACCUM;
      bin_cnt_q <= '0;
      acc_q     <= '0;
      m_data_q  <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      err_len_q <= 1'b0;
      case (state_q)
        S_ACCUM: begin
          s_ready_q <= 1'b1;
          if (beat) begin
            bin_cnt_q <= bin_cnt_q + CNT_W'(1);
            if (frame_end) begin
              state_q   <= S_FLUSH;
              s_ready_q <= 1'b0;
              // Length error when s_last and the bin limit disagree.
              err_len_q <= s_last ^ at_max;
            end
          end
        end
        S_FLUSH: begin
          // Last product lands in acc_d this cycle; latch it as the result.
          state_q   <= S_OUTPUT;
          m_valid_q <= 1'b1;
          m_data_q  <= acc_d;
        end
        S_OUTPUT: begin
          if (m_ready) begin
            state_q   <= S_ACCUM;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            bin_cnt_q <= '0;
          end
        end
        default: begin
          state_q   <= S_ACCUM;
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign err_len  = err_len_q;
  assign rom_addr = bin_cnt_q[ROM_AW-1:0];

endmodule

// File: tb/tb_mfcc_mel_filter_mac.sv
// Self-checking bench for mfcc_mel_filter_mac: a 49-bit and a 40-bit lane share stimulus.
module tb_mfcc_mel_filter_mac;

`ifdef MFCC_MEL_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam int NBINS = 512;

  logic        clk = 1'b0;
  logic        rst, s_valid, s_last, m_ready;
  logic [31:0] s_data;
  logic        s_ready, s_ready40, m_valid, m_valid40;
  logic        m_sat, m_sat40, err_len, err_len40;
  logic [8:0]  rom_addr, rom_addr40;
  logic [7:0]  rom_data, rom_data40;
  logic [48:0] m_data;
  logic [39:0] m_data40;

  logic [31:0] ptab [NBINS];
  logic [7:0]  wtab [NBINS];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data   = wtab[rom_addr];
  assign rom_data40 = wtab[rom_addr40];

  mfcc_mel_filter_mac dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .rom_addr(rom_addr), .rom_data(rom_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat), .err_len(err_len)
  );

  mfcc_mel_filter_mac #(.ACC_W(40)) dut40 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready40), .s_data(s_data),
    .s_last(s_last), .rom_addr(rom_addr40), .rom_data(rom_data40), .m_valid(m_valid40),
    .m_ready(m_ready), .m_data(m_data40), .m_sat(m_sat40), .err_len(err_len40)
  );

  // Reference energy: exact sum, then clamp or wrap to the lane width.
  function automatic logic [63:0] model(input int nb, input int aw, output bit sat);
    longint unsigned t, mx;
    t  = 0;
    mx = (64'd1 << aw) - 64'd1;
    for (int k = 0; k < nb; k++) t += 64'(ptab[k]) * 64'(wtab[k]);
    sat = SAT_EN && (t > mx);
    return sat ? mx : (t & mx);
  endfunction

  // Drive one frame, check timing/energy/flags, hold m_ready low for 'hold' cycles, handshake.
  task automatic run_frame(input string nm, input int len, input bit use_last, input int gap,
                           input int hold, output logic [48:0] got49, output logic [39:0] got40,
                           output logic gsat40);
    int k, cyc, nb;
    bit bt, exp_err, es49, es40;
    logic [63:0] e49, e40;
    k = 0; cyc = 0;
    got49 = 'x; got40 = 'x; gsat40 = 1'bx;
    nb = use_last ? len : NBINS;
    exp_err = !(use_last && len == NBINS);
    e49 = model(nb, 49, es49);
    e40 = model(nb, 40, es40);
    while (k < nb && cyc < 20000) begin
      s_valid = ($urandom_range(99) >= gap);
      s_data  = s_valid ? ptab[k] : $urandom;
      s_last  = s_valid ? (use_last && k == len - 1) : 1'($urandom_range(1));
      checks++;
      if (rom_addr !== 9'(k) || err_len !== 1'b0 || m_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s accum: rom_addr=%0d err_len=%b m_valid=%b, expected rom_addr=%0d err_len=0 m_valid=0",
                 nm, rom_addr, err_len, m_valid, k);
      end
      bt = s_valid && s_ready;
      @(posedge clk); #1;
      cyc++;
      if (bt) k++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (k < nb) begin
      errors++;
      $display("FAIL %s timeout: accepted %0d bins, expected %0d", nm, k, nb);
      return;
    end
    // Cycle after the final beat: FLUSH.
    checks++;
    if (err_len !== exp_err || m_valid !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s flush: err_len=%b m_valid=%b s_ready=%b, expected err_len=%b m_valid=0 s_ready=0",
               nm, err_len, m_valid, s_ready, exp_err);
    end
    @(posedge clk); #1;
    got49 = m_data; got40 = m_data40; gsat40 = m_sat40;
    checks++;
    if (m_valid !== 1'b1 || m_valid40 !== 1'b1 || err_len !== 1'b0) begin
      errors++;
      $display("FAIL %s out_timing: m_valid=%b m_valid40=%b err_len=%b, expected 1 1 0",
               nm, m_valid, m_valid40, err_len);
    end
    checks++;
    if (m_data !== e49[48:0] || m_sat !== es49) begin
      errors++;
      $display("FAIL %s energy49: m_data=%0d m_sat=%b, expected %0d %b", nm, m_data, m_sat, e49[48:0], es49);
    end
    checks++;
    if (m_data40 !== e40[39:0] || m_sat40 !== es40) begin
      errors++;
      $display("FAIL %s energy40: m_data=%0d m_sat=%b, expected %0d %b", nm, m_data40, m_sat40, e40[39:0], es40);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== e49[48:0] || s_ready !== 1'b0 || err_len !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: m_valid=%b m_data=%0d s_ready=%b err_len=%b, expected 1 %0d 0 0",
                 nm, i, m_valid, m_data, s_ready, err_len, e49[48:0]);
      end
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || rom_addr !== 9'd0) begin
      errors++;
      $display("FAIL %s handshake: m_valid=%b s_ready=%b rom_addr=%0d, expected 0 1 0",
               nm, m_valid, s_ready, rom_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_sat !== 1'b0 ||
        err_len !== 1'b0 || rom_addr !== 9'd0) begin
      errors++;
      $display("FAIL reset_values: s_ready=%b m_valid=%b m_data=%0d m_sat=%b err_len=%b rom_addr=%0d, expected all 0",
               s_ready, m_valid, m_data, m_sat, err_len, rom_addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: s_ready=%b, expected 1", s_ready);
    end
  endtask

  task automatic test_ramp(input int hold, input string nm);
    logic [48:0] g; logic [39:0] g40; logic s40;
    for (int k = 0; k < NBINS; k++) begin ptab[k] = 32'd1000; wtab[k] = 8'(k); end
    run_frame(nm, NBINS, 1'b1, 0, hold, g, g40, s40);
    checks++;
    if (g !== 49'd65280000) begin
      errors++;
      $display("FAIL %s const: m_data=%0d, expected 65280000", nm, g);
    end
  endtask

  task automatic test_gaps();
    logic [48:0] g; logic [39:0] g40; logic s40;
    for (int k = 0; k < NBINS; k++) begin ptab[k] = 32'd7; wtab[k] = 8'd1; end
    run_frame("gaps", NBINS, 1'b1, 50, 0, g, g40, s40);
    checks++;
    if (g !== 49'd3584) begin
      errors++;
      $display("FAIL gaps const: m_data=%0d, expected 3584", g);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < NBINS; k++) begin
      ptab[k] = $urandom;
      wtab[k] = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
    end
  endtask

  task automatic test_short_frame();
    logic [48:0] g; logic [39:0] g40; logic s40;
    fill_random();
    run_frame("short_last99", 100, 1'b1, 20, 2, g, g40, s40);
  endtask

  task automatic test_no_last();
    logic [48:0] g; logic [39:0] g40; logic s40;
    fill_random();
    run_frame("no_last", NBINS, 1'b0, 10, 1, g, g40, s40);
  endtask

  task automatic test_rst_mid();
    logic [48:0] g; logic [39:0] g40; logic s40;
    int cyc;
    fill_random();
    cyc = 0;
    s_valid = 1'b1; s_last = 1'b0;
    while (rom_addr != 9'd300 && cyc < 2000) begin
      s_data = ptab[rom_addr];
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (rom_addr !== 9'd300) begin
      errors++;
      $display("FAIL rst_mid reach300: rom_addr=%0d, expected 300", rom_addr);
    end
    rst = 1'b1; s_valid = 1'b0;
    #1;
    checks++;
    if (rom_addr !== 9'd0 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid clear: rom_addr=%0d s_ready=%b m_valid=%b, expected 0 0 0", rom_addr, s_ready, m_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < NBINS; k++) begin ptab[k] = 32'd2; wtab[k] = 8'd3; end
    run_frame("rst_mid", NBINS, 1'b1, 0, 0, g, g40, s40);
    checks++;
    if (g !== 49'd3072) begin
      errors++;
      $display("FAIL rst_mid const: m_data=%0d, expected 3072", g);
    end
  endtask

  task automatic test_sat();
    logic [48:0] g; logic [39:0] g40, ex; logic s40, exs;
    for (int k = 0; k < NBINS; k++) begin ptab[k] = 32'hFFFF_FFFF; wtab[k] = 8'd255; end
    run_frame("sat", NBINS, 1'b1, 0, 0, g, g40, s40);
    // 512*255*(2^32-1) = 130560*2^32 - 130560, and 130560*2^32 is a multiple of 2^40.
    ex  = SAT_EN ? 40'hFF_FFFF_FFFF : 40'(64'd1099511627776 - 64'd130560);
    exs = SAT_EN;
    checks++;
    if (g40 !== ex || s40 !== exs) begin
      errors++;
      $display("FAIL sat const40: m_data=%0d m_sat=%b, expected %0d %b", g40, s40, ex, exs);
    end
  endtask

  task automatic test_back_to_back();
    logic [48:0] g; logic [39:0] g40; logic s40;
    for (int f = 0; f < 4; f++) begin
      fill_random();
      run_frame($sformatf("b2b%0d", f), ($urandom_range(1) == 1) ? NBINS : $urandom_range(NBINS - 1, 1),
                1'b1, $urandom_range(60), $urandom_range(5), g, g40, s40);
    end
  endtask

  initial begin
    test_reset();
    test_ramp(0, "ramp");
    test_ramp(10, "backpressure");
    test_gaps();
    test_short_frame();
    test_no_last();
    test_rst_mid();
    test_sat();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
